// File: rtl/mac_controller.sv
// Sequencer for the MAC datapath: pulls operand pairs through valid/ready and
// drives the enable/clear strobes for operand, product and accumulator stages.
module mac_controller #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [CNT_W-1:0] op_idx,
    output logic             op_en,
    output logic             mul_en,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             mul_en_q, acc_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            mul_en_q    <= 1'b0;
            acc_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            mul_en_q    <= op_en;
            acc_en_q    <= mul_en_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        acc_clr     = 1'b0;
        op_ready    = (state_q == StRun) && (remaining_q != '0);
        op_en       = op_ready & op_valid;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StClear;
                    len_d       = len;
                    remaining_d = len;
                    idx_d       = '0;
                end
            end
            StClear: begin
                acc_clr = 1'b1;
                state_d = (len_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (op_en) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    idx_d       = idx_q + CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = StDrain;
                end
            end
            // Wait until the last product has moved into the accumulate stage.
            StDrain: begin
                if (!mul_en_q) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign op_idx = idx_q;
    assign mul_en = mul_en_q;
    assign acc_en = acc_en_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_mac_controller.sv
// Directed, table-driven bench for mac_controller; records per-cycle strobes of
// each run and compares them against hand-computed cycle numbers.
module tb_mac_controller;

    localparam int unsigned CNT_W = 8;
    localparam int          LIMIT = 300;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready, op_en, mul_en, acc_en, acc_clr, busy, done;
    logic [CNT_W-1:0] op_idx;

    mac_controller #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_idx   (op_idx),
        .op_en    (op_en),
        .mul_en   (mul_en),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic r_op[0:LIMIT], r_mul[0:LIMIT], r_acc[0:LIMIT], r_clr[0:LIMIT];
    logic r_done[0:LIMIT], r_busy[0:LIMIT];
    int   r_idx[0:LIMIT];

    typedef struct {
        int n;
        int slo;
        int shi;
        int exp_done;
        int exp_ops;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic record(input int c);
        r_op[c]   = op_en;
        r_mul[c]  = mul_en;
        r_acc[c]  = acc_en;
        r_clr[c]  = acc_clr;
        r_done[c] = done;
        r_busy[c] = busy;
        r_idx[c]  = int'(op_idx);
    endtask

    // Cycle 0 is the cycle in which start is sampled; op_valid is low in
    // cycles slo..shi. Stops two cycles after done or at LIMIT.
    task automatic run_vec(input int n, input int slo, input int shi, input bit hold,
                           output int done_cyc, output int last);
        @(negedge clk);
        start    = 1'b1;
        len      = CNT_W'(n);
        op_valid = 1'b1;
        #1 record(0);
        done_cyc = -1;
        last     = 0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            op_valid = !(c >= slo && c <= shi);
            #1 record(c);
            last = c;
            if (r_done[c] && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 2) break;
        end
    endtask

    task automatic check_run(input string name, input int n, input int exp_done,
                             input int exp_ops, input int done_cyc, input int last);
        int hi, n_op, n_mul, n_acc, n_clr, n_done, pipe_err, idx_err, ovl, busy_err, clr_cyc;
        hi = (done_cyc >= 0) ? done_cyc + 1 : last;
        n_op = 0; n_mul = 0; n_acc = 0; n_clr = 0; n_done = 0;
        pipe_err = 0; idx_err = 0; ovl = 0; busy_err = 0; clr_cyc = -1;
        for (int c = 0; c <= hi; c++) begin
            if (r_op[c]) begin
                if (r_idx[c] != n_op) idx_err++;
                n_op++;
            end
            n_mul += int'(r_mul[c]);
            n_acc += int'(r_acc[c]);
            n_done += int'(r_done[c]);
            if (r_clr[c]) begin
                n_clr++;
                if (clr_cyc < 0) clr_cyc = c;
            end
            if (r_clr[c] && r_acc[c]) ovl++;
            if (c == 0) begin
                if (r_mul[c] || r_acc[c]) pipe_err++;
            end else begin
                if (r_mul[c] != r_op[c-1]) pipe_err++;
                if (r_acc[c] != r_mul[c-1]) pipe_err++;
            end
            if (r_busy[c] != (c >= 1 && c <= exp_done)) busy_err++;
        end
        chk({name, " done_cycle"}, done_cyc, exp_done);
        chk({name, " done_pulses"}, n_done, 1);
        chk({name, " acc_clr_cycle"}, clr_cyc, 1);
        chk({name, " acc_clr_pulses"}, n_clr, 1);
        chk({name, " op_en_pulses"}, n_op, exp_ops);
        chk({name, " mul_en_pulses"}, n_mul, exp_ops);
        chk({name, " acc_en_pulses"}, n_acc, exp_ops);
        chk({name, " pipeline_errs"}, pipe_err, 0);
        chk({name, " op_idx_errs"}, idx_err, 0);
        chk({name, " clr_acc_overlap"}, ovl, 0);
        chk({name, " busy_errs"}, busy_err, 0);
        if (done_cyc >= 0) chk({name, " final_op_idx"}, r_idx[done_cyc], n);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " done"}, int'(done), 0);
        chk({name, " op_ready"}, int'(op_ready), 0);
        chk({name, " op_en"}, int'(op_en), 0);
        chk({name, " mul_en"}, int'(mul_en), 0);
        chk({name, " acc_en"}, int'(acc_en), 0);
        chk({name, " acc_clr"}, int'(acc_clr), 0);
        chk({name, " op_idx"}, int'(op_idx), 0);
    endtask

    initial begin
        int dc, last, cnt, seen;

        vecs[0] = '{n: 4,   slo: 0, shi: -1, exp_done: 8,   exp_ops: 4};
        vecs[1] = '{n: 3,   slo: 3, shi: 4,  exp_done: 9,   exp_ops: 3};
        vecs[2] = '{n: 0,   slo: 0, shi: -1, exp_done: 2,   exp_ops: 0};
        vecs[3] = '{n: 1,   slo: 0, shi: -1, exp_done: 5,   exp_ops: 1};
        vecs[4] = '{n: 2,   slo: 2, shi: 2,  exp_done: 7,   exp_ops: 2};
        vecs[5] = '{n: 255, slo: 0, shi: -1, exp_done: 259, exp_ops: 255};

        op_valid = 1'b1;
        #12;
        chk_quiet("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk_quiet("idle_after_reset");

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v].n, vecs[v].slo, vecs[v].shi, 1'b0, dc, last);
            check_run($sformatf("vec%0d_len%0d", v, vecs[v].n), vecs[v].n,
                      vecs[v].exp_done, vecs[v].exp_ops, dc, last);
        end

        // start held high: one run only, the next starts from the following IDLE.
        run_vec(2, 0, -1, 1'b1, dc, last);
        check_run("hold_len2", 2, 6, 2, dc, last);
        chk("hold_restart_acc_clr", int'(r_clr[last]), 1);
        chk("hold_restart_busy", int'(r_busy[last]), 1);
        chk("hold_idle_gap_busy", int'(r_busy[dc+1]), 0);
        start = 1'b0;
        seen = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (done && seen < 0) seen = c;
        end
        chk("hold_second_run_done_offset", seen, 5);

        // Asynchronous reset mid-run aborts without a done.
        @(negedge clk);
        start    = 1'b1;
        len      = CNT_W'(8);
        op_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 chk("abort_running_op_en", int'(op_en), 1);
        reset = 1'b0;
        #1 chk_quiet("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1 cnt += int'(done) + int'(busy);
        end
        chk("abort_no_done_or_busy", cnt, 0);

        run_vec(4, 0, -1, 1'b0, dc, last);
        check_run("after_abort_len4", 4, 8, 4, dc, last);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
